// File: rtl/game_level_controller.sv
// -----------------------------------------------------------------------------
// game_level_controller
//
// Round sequencer for the whack-a-mole game. It steps a round through
// IDLE -> READY (countdown) -> PLAY -> OVER and keeps a per-second timer for
// the HEX display. While playing, it raises the level as the score crosses
// multiples of LEVEL_UP_HITS. Each level shortens the mole timing value
// `speed`, which is floored at MIN_SPEED.
//
// Optional feature: define GAME_HIGH_SCORE_EN to keep the best final score
// across rounds. Without the macro, high_score is tied to zero.
//
// Ports:
//   clock         in   1   system clock, all logic on posedge
//   resetn        in   1   asynchronous active-low reset
//   start         in   1   start button (level), acted on at its rising edge
//   score         in   8   live score from the player block
//   game          out  1   high only while playing
//   speed         out  28  mole timing value for the display controller
//   level         out  3   current level
//   seconds_left  out  8   countdown value for the HEX display
//   state         out  2   IDLE=0, READY=1, PLAY=2, OVER=3
//   game_over     out  1   high in OVER
//   final_score   out  8   score latched when play ends
//   high_score    out  8   best final score (zero unless GAME_HIGH_SCORE_EN)
// -----------------------------------------------------------------------------
module game_level_controller #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned READY_SECS    = 3,
    parameter int unsigned ROUND_SECS    = 60,
    parameter int unsigned BASE_SPEED    = 50_000_000,
    parameter int unsigned SPEED_STEP    = 6_000_000,
    parameter int unsigned MIN_SPEED     = 10_000_000,
    parameter int unsigned LEVEL_UP_HITS = 8,
    parameter int unsigned MAX_LEVEL     = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  score,
    output logic        game,
    output logic [27:0] speed,
    output logic [2:0]  level,
    output logic [7:0]  seconds_left,
    output logic [1:0]  state,
    output logic        game_over,
    output logic [7:0]  final_score,
    output logic [7:0]  high_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned DIV_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]       READY_LOAD = 8'(READY_SECS);
    localparam logic [7:0]       ROUND_LOAD = 8'(ROUND_SECS);
    localparam logic [27:0]      BASE_W     = 28'(BASE_SPEED);
    localparam logic [27:0]      STEP_W     = 28'(SPEED_STEP);
    localparam logic [27:0]      MIN_W      = 28'(MIN_SPEED);
    localparam logic [27:0]      SPAN_W     = 28'(BASE_SPEED - MIN_SPEED);
    localparam logic [2:0]       MAX_LVL_W  = 3'(MAX_LEVEL);
    localparam logic [8:0]       HITS_W     = 9'(LEVEL_UP_HITS);

    state_t           state_q;
    state_t           state_nx;
    logic             start_d;
    logic             start_rise;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [7:0]       seconds_nx;
    logic             new_round;
    logic             end_round;
    logic [8:0]       level_thr;
    logic             level_up;

    // Speed for a given level, saturating at the MIN_SPEED floor so the
    // subtraction can never wrap.
    function automatic logic [27:0] speed_for(input logic [2:0] lvl);
        logic [27:0] reduction;
        reduction = 28'(lvl) * STEP_W;
        if (reduction >= SPAN_W) begin
            return MIN_W;
        end
        return BASE_W - reduction;
    endfunction

    assign start_rise = start & ~start_d;
    assign tick       = (div_q == DIV_LAST) && ((state_q == READY) || (state_q == PLAY));
    assign state      = state_q;

    // The threshold is a 9-bit product so (MAX_LEVEL+1)*LEVEL_UP_HITS cannot
    // overflow against the 8-bit score.
    assign level_thr = (9'(level) + 9'd1) * HITS_W;
    assign level_up  = (state_q == PLAY) && (level < MAX_LVL_W) && ({1'b0, score} >= level_thr);

    // Next-state and countdown decode
    always_comb begin
        state_nx   = state_q;
        seconds_nx = seconds_left;
        new_round  = 1'b0;
        end_round  = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_nx   = READY;
                    seconds_nx = READY_LOAD;
                    new_round  = 1'b1;
                end
            end
            READY: begin
                if (tick) begin
                    if (seconds_left == 8'd1) begin
                        state_nx   = PLAY;
                        seconds_nx = ROUND_LOAD;
                    end else begin
                        seconds_nx = seconds_left - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (seconds_left == 8'd1) begin
                        state_nx   = OVER;
                        seconds_nx = 8'd0;
                        end_round  = 1'b1;
                    end else begin
                        seconds_nx = seconds_left - 8'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, start edge and registered state-decoded outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            start_d      <= 1'b0;
            game         <= 1'b0;
            game_over    <= 1'b0;
            seconds_left <= 8'd0;
        end else begin
            state_q      <= state_nx;
            start_d      <= start;
            game         <= (state_nx == PLAY);
            game_over    <= (state_nx == OVER);
            seconds_left <= seconds_nx;
        end
    end

    // One-second divider; restarts on every state entry so each phase
    // lasts a whole number of seconds.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
        end else if ((state_nx != state_q) || (state_q == IDLE) || (state_q == OVER) || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Level and speed; speed lags level by one register stage
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level <= 3'd0;
            speed <= BASE_W;
        end else if (new_round) begin
            level <= 3'd0;
            speed <= BASE_W;
        end else begin
            if (level_up) begin
                level <= level + 3'd1;
            end
            speed <= speed_for(level);
        end
    end

    // Score captured on the exit edge; the player's later clear of score is
    // not seen because this only loads on end_round.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            final_score <= 8'd0;
        end else if (end_round) begin
            final_score <= score;
        end
    end

`ifdef GAME_HIGH_SCORE_EN
    logic [7:0] high_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            high_q <= 8'd0;
        end else if (end_round && (score > high_q)) begin
            high_q <= score;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = 8'd0;
`endif

endmodule
